// File: rtl/amm_slave_responder.sv
// Avalon-MM burst slave: write bursts land in a word-addressed RAM, read bursts return through
// a READ_LAT-deep pipeline. Define RESPONDER_BACKPRESSURE_EN for LFSR-driven waitrequest stalls.
module amm_slave_responder #(
  parameter int unsigned AMM_ADDR_W  = 31,
  parameter int unsigned AMM_DATA_W  = 64,
  parameter int unsigned AMM_BURST_W = 11,
  parameter int unsigned MEM_ADDR_W  = 10,
  parameter int unsigned READ_LAT    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [AMM_ADDR_W-1:0]   address_i,
  input  logic                    read_i,
  input  logic                    write_i,
  input  logic [AMM_DATA_W-1:0]   writedata_i,
  input  logic [AMM_DATA_W/8-1:0] byteenable_i,
  input  logic [AMM_BURST_W-1:0]  burstcount_i,
  output logic                    waitrequest_o,
  output logic [AMM_DATA_W-1:0]   readdata_o,
  output logic                    readdatavalid_o,
  output logic                    busy_o,
  output logic                    proto_err_o
);

  localparam int unsigned NumBytes = AMM_DATA_W / 8;
  localparam int unsigned MemDepth = 2 ** MEM_ADDR_W;

  typedef enum logic [1:0] {StIdle, StWrBurst, StRdBurst} state_e;

  state_e                 state_q, state_d;
  logic [MEM_ADDR_W-1:0]  addr_q, addr_d;
  logic [AMM_BURST_W-1:0] cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic                   stall;
  logic                   wr_acc, rd_acc;
  logic                   bc_zero;
  logic [AMM_BURST_W-1:0] bc_eff;
  logic [MEM_ADDR_W-1:0]  base_addr;
  logic                   mem_we;
  logic [MEM_ADDR_W-1:0]  mem_waddr;
  logic                   rd_issue;

  // Only the low MEM_ADDR_W address bits select a RAM word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address_i[AMM_ADDR_W-1:MEM_ADDR_W];
  assign base_addr        = address_i[MEM_ADDR_W-1:0];

`ifdef RESPONDER_BACKPRESSURE_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign waitrequest_o = rst_i | (state_q == StRdBurst) | stall;
  assign wr_acc        = write_i & ~waitrequest_o;
  assign rd_acc        = read_i & ~waitrequest_o;
  assign bc_zero       = (burstcount_i == '0);
  assign bc_eff        = bc_zero ? AMM_BURST_W'(1) : burstcount_i;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    rd_issue  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Write wins over a simultaneous read.
        if (wr_acc) begin
          mem_we    = 1'b1;
          mem_waddr = base_addr;
          if (bc_zero || read_i) begin
            err_d = 1'b1;
          end
          if (bc_eff != AMM_BURST_W'(1)) begin
            cnt_d   = bc_eff - AMM_BURST_W'(1);
            addr_d  = base_addr + MEM_ADDR_W'(1);
            state_d = StWrBurst;
          end
        end else if (rd_acc) begin
          if (bc_zero) begin
            err_d = 1'b1;
          end
          addr_d  = base_addr;
          cnt_d   = bc_eff;
          state_d = StRdBurst;
        end
      end
      StWrBurst: begin
        if (read_i) begin
          err_d = 1'b1;
        end
        if (wr_acc) begin
          mem_we = 1'b1;
          addr_d = addr_q + MEM_ADDR_W'(1);
          cnt_d  = cnt_q - AMM_BURST_W'(1);
          if (cnt_q == AMM_BURST_W'(1)) begin
            state_d = StIdle;
          end
        end
      end
      StRdBurst: begin
        rd_issue = 1'b1;
        addr_d   = addr_q + MEM_ADDR_W'(1);
        cnt_d    = cnt_q - AMM_BURST_W'(1);
        if (cnt_q == AMM_BURST_W'(1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // RAM contents are deliberately not reset.
  logic [AMM_DATA_W-1:0] mem_q [MemDepth];

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (byteenable_i[b]) begin
          mem_q[mem_waddr][b*8 +: 8] <= writedata_i[b*8 +: 8];
        end
      end
    end
  end

  logic [READ_LAT-1:0]   vld_q;
  logic [AMM_DATA_W-1:0] dat_q [READ_LAT];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_issue;
      if (rd_issue) begin
        dat_q[0] <= mem_q[addr_q];
      end
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign readdatavalid_o = vld_q[READ_LAT-1];
  assign readdata_o      = dat_q[READ_LAT-1];
  assign busy_o          = (state_q != StIdle) | (|vld_q);
  assign proto_err_o     = err_q;

endmodule
